riscv_pipe_ctrl: RTL and testbench
==================================

# riscv_pipe_ctrl

Pipeline hazard controller for the 5-stage RV32 core. Watches the ID-stage source registers, the ID/EX control register, the EX-stage branch result and the data-memory handshake in MEM. It drives the per-stage stall and flush strobes: load-use bubble, taken-branch squash, and multi-cycle memory wait with timeout. It sits beside the pipeline registers and adds no datapath.

## Interface
- `REGFILE_COUNT`, 32, number of architectural registers; `RA_W = $clog2(REGFILE_COUNT)`
- `MEM_TIMEOUT`, 16, max cycles a data-memory access may stall before abort (≥2)
- `XLEN`, 32, width of performance counters
---
- `clk_i` in 1: single clock, rising edge
- `rst_ni` in 1: reset, asynchronous assert, active-low
- `id_rs1_i` in RA_W: rs1 of instruction in ID
- `id_rs2_i` in RA_W: rs2 of instruction in ID
- `ex_rd_i` in RA_W: rd held in ID/EX register
- `ex_mem_read_i` in 1: mem_read held in ID/EX register
- `ex_branch_taken_i` in 1: branch in EX resolved taken
- `mem_req_i` in 1: MEM stage has a load/store in flight
- `mem_ready_i` in 1: data memory completes access this cycle
- `pc_stall_o` out 1: hold PC
- `if_id_stall_o` out 1: hold IF/ID register
- `id_ex_stall_o` out 1: hold ID/EX register
- `ex_mem_stall_o` out 1: hold EX/MEM register
- `if_id_flush_o` out 1: load NOP into IF/ID
- `id_ex_flush_o` out 1: load NOP (all ctrl 0) into ID/EX
- `ex_mem_flush_o` out 1: load NOP into EX/MEM
- `mem_err_o` out 1: one-cycle pulse on memory timeout

## Operation
- FSM states: RUN, MEM_WAIT, MEM_ERR. Registered `wait_cnt`, width `$clog2(MEM_TIMEOUT+1)`.
- `mem_stall = mem_req_i & ~mem_ready_i`.
- `load_use = ex_mem_read_i & (ex_rd_i != 0) & (ex_rd_i == id_rs1_i | ex_rd_i == id_rs2_i)`. Register x0 never creates a hazard.
- All outputs are combinational from the state and the current inputs, with this priority:
  1. State MEM_ERR: all three flushes = 1 and `mem_err_o` = 1. All stalls = 0. Next state RUN.
  2. `mem_stall`: all four stalls = 1 and all flushes = 0. A pending taken branch or load-use in EX/ID is held and acted on after release.
  3. `ex_branch_taken_i`: `if_id_flush_o` = `id_ex_flush_o` = 1 and no stall. This squashes a coincident load-use.
  4. `load_use`: `pc_stall_o` = `if_id_stall_o` = 1 and `id_ex_flush_o` = 1, giving one bubble. The hazard clears next cycle because ID/EX then holds the bubble.
- State transitions:
  - RUN → MEM_WAIT when `mem_stall`. `wait_cnt` loads 1.
  - MEM_WAIT → RUN when `mem_ready_i`. `wait_cnt` clears and the stall drops in that same cycle.
  - In MEM_WAIT with `mem_stall` and `wait_cnt == MEM_TIMEOUT-1`, go to MEM_ERR and clear `wait_cnt`.
  - Otherwise `wait_cnt` increments.
- A stall and a flush are never both asserted on the same pipeline register.

## Timing
- Reset (async, `rst_ni` = 0):
  - State = RUN and `wait_cnt` = 0.
  - All outputs read 0 while in reset.
  - A reset during MEM_WAIT or MEM_ERR aborts immediately with no `mem_err_o` pulse.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 squashed instructions with 0 stall cycles.
- A memory access taking N cycles (ready on cycle N) stalls for N-1 cycles.
- A stall lasting MEM_TIMEOUT cycles without ready is followed by 1 MEM_ERR cycle, then RUN.
- A `mem_ready_i` arriving during MEM_ERR is ignored.

## Configuration
- `RISCV_PIPE_PERF_EN` defined:
  - Adds outputs `stall_cnt_o` [XLEN] and `flush_cnt_o` [XLEN], both reset to 0.
  - `stall_cnt_o` increments each cycle `pc_stall_o` = 1.
  - `flush_cnt_o` increments each cycle any flush = 1.
  - Both counters wrap modulo 2^XLEN.
- `RISCV_PIPE_PERF_EN` undefined: the ports and counters are absent and the rest of the behaviour is identical.

## Structure
- Shared package `riscv_pkg` holds:
  - the `pipe_state_e` enum (RUN, MEM_WAIT, MEM_ERR);
  - the `REGFILE_COUNT` and `RA_W` constants;
  - a packed `pipe_ctrl_t` struct bundling the stall and flush strobes.
- Sub-module `riscv_hazard_detect` is purely combinational and produces `load_use`. It is reused by the forwarding unit.
- The FSM and counters live in the top module.

## Test plan
- Load-use: `ex_mem_read_i`=1, `ex_rd_i`=5, `id_rs2_i`=5 → one cycle of `pc_stall_o`=`if_id_stall_o`=`id_ex_flush_o`=1; next cycle with `ex_mem_read_i`=0, all outputs are 0.
- x0 exemption: `ex_mem_read_i`=1, `ex_rd_i`=0, `id_rs1_i`=0 → all outputs 0.
- Branch over load-use: `ex_branch_taken_i`=1 together with the load-use above → `if_id_flush_o`=`id_ex_flush_o`=1 and `pc_stall_o`=0.
- Memory wait: `mem_req_i`=1 with ready on the 4th cycle → 3 cycles of all-stall, then the state returns to RUN; a branch held during the wait flushes on the release cycle.
- Timeout with MEM_TIMEOUT=16: `mem_req_i`=1 and ready never asserted → 16 stall cycles, then 1 cycle of `mem_err_o`=1 with all flushes, then RUN.
- Reset mid-wait: drop `rst_ni` at wait cycle 7 → outputs go to 0 immediately, no `mem_err_o`, and after release the next timeout count restarts from 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the RV32 pipeline control: FSM state encoding, register-file
// geometry and the bundle of per-stage stall/flush strobes.
package riscv_pkg;

  localparam int REGFILE_COUNT = 32;
  localparam int RA_W          = $clog2(REGFILE_COUNT);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    MEM_ERR
  } pipe_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/riscv_hazard_detect.sv
// Combinational load-use detector: a load in EX whose rd feeds the instruction in ID.
// Register x0 never creates a hazard. Shared with the forwarding unit.
module riscv_hazard_detect #(
  parameter int RA_W = riscv_pkg::RA_W
) (
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_mem_read,
  output logic            load_use
);

  assign load_use = ex_mem_read & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use bubble, branch squash,
// memory wait with timeout. Optional perf counters under RISCV_PIPE_PERF_EN.
module riscv_pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int REGFILE_COUNT = 32,
  parameter int MEM_TIMEOUT   = 16,
  parameter int XLEN          = 32,
  localparam int RA_W         = $clog2(REGFILE_COUNT)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic            ex_mem_read_i,
  input  logic            ex_branch_taken_i,
  input  logic            mem_req_i,
  input  logic            mem_ready_i,
  output logic            pc_stall_o,
  output logic            if_id_stall_o,
  output logic            id_ex_stall_o,
  output logic            ex_mem_stall_o,
  output logic            if_id_flush_o,
  output logic            id_ex_flush_o,
  output logic            ex_mem_flush_o,
  output logic            mem_err_o
`ifdef RISCV_PIPE_PERF_EN
  ,
  output logic [XLEN-1:0] stall_cnt_o,
  output logic [XLEN-1:0] flush_cnt_o
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  pipe_state_e   state, state_nx;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
  pipe_ctrl_t    ctrl;
  logic          err;
  logic          load_use;
  logic          mem_stall;

  riscv_hazard_detect #(.RA_W(RA_W)) u_hazard (
    .id_rs1      (id_rs1_i),
    .id_rs2      (id_rs2_i),
    .ex_rd       (ex_rd_i),
    .ex_mem_read (ex_mem_read_i),
    .load_use    (load_use)
  );

  assign mem_stall = mem_req_i & ~mem_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  always_comb begin
    ctrl        = '0;
    err         = 1'b0;
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    if (state == MEM_ERR) begin
      // Abort cycle: squash everything younger than WB; a late ready is ignored.
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
      ctrl.ex_mem_flush = 1'b1;
      err               = 1'b1;
      state_nx          = RUN;
      wait_cnt_nx       = '0;
    end else begin
      if (mem_stall) begin
        // Freezing the whole front end keeps any pending branch/load-use intact.
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_stall  = 1'b1;
        ctrl.id_ex_stall  = 1'b1;
        ctrl.ex_mem_stall = 1'b1;
      end else if (ex_branch_taken_i) begin
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
      end else if (load_use) begin
        ctrl.pc_stall    = 1'b1;
        ctrl.if_id_stall = 1'b1;
        ctrl.id_ex_flush = 1'b1;
      end

      if (state == RUN) begin
        if (mem_stall) begin
          state_nx    = MEM_WAIT;
          wait_cnt_nx = CW'(1);
        end
      end else if (!mem_stall) begin
        state_nx    = RUN;
        wait_cnt_nx = '0;
      end else if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
        state_nx    = MEM_ERR;
        wait_cnt_nx = '0;
      end else begin
        wait_cnt_nx = wait_cnt + CW'(1);
      end
    end
  end

  // Outputs are combinational, so they are forced quiet while reset is held.
  assign pc_stall_o     = rst_ni & ctrl.pc_stall;
  assign if_id_stall_o  = rst_ni & ctrl.if_id_stall;
  assign id_ex_stall_o  = rst_ni & ctrl.id_ex_stall;
  assign ex_mem_stall_o = rst_ni & ctrl.ex_mem_stall;
  assign if_id_flush_o  = rst_ni & ctrl.if_id_flush;
  assign id_ex_flush_o  = rst_ni & ctrl.id_ex_flush;
  assign ex_mem_flush_o = rst_ni & ctrl.ex_mem_flush;
  assign mem_err_o      = rst_ni & err;

`ifdef RISCV_PIPE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (pc_stall_o)
        stall_cnt_o <= stall_cnt_o + XLEN'(1);
      if (if_id_flush_o | id_ex_flush_o | ex_mem_flush_o)
        flush_cnt_o <= flush_cnt_o + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed bench for riscv_pipe_ctrl: single-cycle vector table plus
// memory-wait, timeout and reset-abort sequences.
module tb_riscv_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_err;
`ifdef RISCV_PIPE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_pipe_ctrl #(.REGFILE_COUNT(32), .MEM_TIMEOUT(16), .XLEN(32)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .ex_rd_i           (ex_rd),
    .ex_mem_read_i     (ex_mem_read),
    .ex_branch_taken_i (ex_branch_taken),
    .mem_req_i         (mem_req),
    .mem_ready_i       (mem_ready),
    .pc_stall_o        (pc_stall),
    .if_id_stall_o     (if_id_stall),
    .id_ex_stall_o     (id_ex_stall),
    .ex_mem_stall_o    (ex_mem_stall),
    .if_id_flush_o     (if_id_flush),
    .id_ex_flush_o     (id_ex_flush),
    .ex_mem_flush_o    (ex_mem_flush),
    .mem_err_o         (mem_err)
`ifdef RISCV_PIPE_PERF_EN
    ,
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
`endif
  );

  // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, ex_mem_flush, mem_err}
  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_LU    = 8'hC4;
  localparam logic [7:0] O_BR    = 8'h0C;
  localparam logic [7:0] O_STALL = 8'hF0;
  localparam logic [7:0] O_ERR   = 8'h0F;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       mrd, br, req, rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [7:0] outs();
    return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_err};
  endfunction

  task automatic chk(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = outs();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: outputs=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mrd, input logic br, input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_mem_read = mrd; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_timeout(input string tag);
    for (int i = 0; i < 16; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0);
      #1 chk({tag, "_stall"}, O_STALL);
      cyc();
    end
    set_in(0, 0, 0, 0, 0, 1, 1);
    #1 chk({tag, "_err"}, O_ERR);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 chk({tag, "_idle"}, O_NONE);
    cyc();
    set_in(0, 5, 5, 1, 0, 0, 0);
    #1 chk({tag, "_run_loaduse"}, O_LU);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"idle",          0,  0, 0, 0, 0, 0, 0, O_NONE};
    vecs[1] = '{"loaduse_rs2",   1,  5, 5, 1, 0, 0, 0, O_LU};
    vecs[2] = '{"after_bubble",  1,  5, 5, 0, 0, 0, 0, O_NONE};
    vecs[3] = '{"loaduse_rs1",   9,  3, 9, 1, 0, 0, 0, O_LU};
    vecs[4] = '{"x0_exempt",     0,  0, 0, 1, 0, 0, 0, O_NONE};
    vecs[5] = '{"no_match",      6,  7, 5, 1, 0, 0, 0, O_NONE};
    vecs[6] = '{"branch",        0,  0, 0, 0, 1, 0, 0, O_BR};
    vecs[7] = '{"branch_over_lu",1,  5, 5, 1, 1, 0, 0, O_BR};
    vecs[8] = '{"mem_one_cycle", 0,  0, 0, 0, 0, 1, 1, O_NONE};
    vecs[9] = '{"loaduse_rd31", 31, 31, 31, 1, 0, 0, 0, O_LU};

    rst_ni = 1'b0;
    set_in(1, 5, 5, 1, 1, 1, 0);
    #3 chk("reset_outputs", O_NONE);
    #9 rst_ni = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc();

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mrd,
             vecs[i].br, vecs[i].req, vecs[i].rdy);
      #1 chk(vecs[i].name, vecs[i].exp);
      cyc();
    end

    // Ready on the 4th cycle, taken branch held throughout the wait.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 1, 1, 0);
      #1 chk("memwait_stall", O_STALL);
      cyc();
    end
    set_in(0, 0, 0, 0, 1, 1, 1);
    #1 chk("memwait_release_branch", O_BR);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 chk("memwait_idle", O_NONE);
    cyc();

    run_timeout("timeout");

    // Reset at wait cycle 7 must abort without an error pulse.
    for (int i = 0; i < 7; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0);
      #1 chk("prereset_stall", O_STALL);
      if (i < 6) cyc();
    end
    rst_ni = 1'b0;
    #1 chk("reset_mid_wait", O_NONE);
    cyc();
    chk("reset_held_no_err", O_NONE);
    set_in(0, 0, 0, 0, 0, 0, 0);
    #3 rst_ni = 1'b1;
    cyc();
    run_timeout("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
